// File: rtl/cam_config_sequencer.sv
// Camera power-up and register-table configuration sequencer.
// Sequences the power_down and reset pins, then walks a {reg,val} table and
// issues each entry as a write request to an SCCB master, retrying on NACK.
module cam_config_sequencer #(
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned PWRUP_CYC   = 250_000,
  parameter int unsigned RST_CYC     = 25_000,
  parameter int unsigned POSTRST_CYC = 250_000,
  parameter int unsigned DELAY_CYC   = 250_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              cam_pwdn,
  output logic              cam_rst_n,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [7:0]        req_dev,
  output logic [7:0]        req_reg,
  output logic [7:0]        req_val,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_idx
);

  localparam int unsigned MAX_A   = (PWRUP_CYC > RST_CYC) ? PWRUP_CYC : RST_CYC;
  localparam int unsigned MAX_B   = (POSTRST_CYC > DELAY_CYC) ? POSTRST_CYC : DELAY_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0]     PWRUP_LAST   = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0]     RST_LAST     = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]     POSTRST_LAST = CW'(POSTRST_CYC - 1);
  localparam logic [CW-1:0]     DELAY_LAST   = CW'(DELAY_CYC - 1);
  localparam logic [RW-1:0]     RETRY_MAX    = RW'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] LAST_ADDR    = '1;
  localparam logic [15:0]       END_WORD     = 16'hFFFF;
  localparam logic [15:0]       DELAY_WORD   = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_RSTA, S_RSTW, S_FETCH, S_DECODE,
    S_ISSUE, S_WAITR, S_DLY, S_FIN, S_ERR
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   retry;
  logic            auto_start;
  logic            go;
  logic            at_last;
  logic            counting;

  assign go       = start | auto_start;
  assign at_last  = (rom_addr == LAST_ADDR);
  assign counting = (state == S_PWRUP) || (state == S_RSTA) ||
                    (state == S_RSTW)  || (state == S_DLY);

  // Auto-start: the first cycle after reset release behaves like a start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_start <= 1'b1;
    else        auto_start <= 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_FIN, S_ERR: if (go) state_next = S_PWRUP;
      S_PWRUP:  if (cnt == PWRUP_LAST)   state_next = S_RSTA;
      S_RSTA:   if (cnt == RST_LAST)     state_next = S_RSTW;
      S_RSTW:   if (cnt == POSTRST_LAST) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (rom_data == END_WORD)        state_next = S_FIN;
        else if (rom_data == DELAY_WORD) state_next = S_DLY;
        else                             state_next = S_ISSUE;
      end
      S_ISSUE:  if (req_ready) state_next = S_WAITR;
      S_WAITR: begin
        if (rsp_valid) begin
          if (!rsp_nack)               state_next = at_last ? S_FIN : S_FETCH;
          else if (retry == RETRY_MAX) state_next = S_ERR;
          else                         state_next = S_ISSUE;
        end
      end
      S_DLY:    if (cnt == DELAY_LAST) state_next = at_last ? S_FIN : S_FETCH;
      default:  state_next = S_IDLE;
    endcase
  end

  // Pin and status outputs decoded straight from state so reset clears them at once
  always_comb begin
    cam_pwdn  = 1'b0;
    cam_rst_n = 1'b1;
    req_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE:  begin cam_pwdn = 1'b1; busy = 1'b0; end
      S_RSTA:  cam_rst_n = 1'b0;
      S_ISSUE: req_valid = 1'b1;
      S_FIN:   begin busy = 1'b0; done = 1'b1; end
      S_ERR:   begin busy = 1'b0; error = 1'b1; end
      default: ;
    endcase
  end

  // Wait counter: restarts at 0 on each state entry, only runs in timed states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt <= '0;
    else if (counting && state_next == state) cnt <= cnt + 1'b1;
    else                                     cnt <= '0;
  end

  // Table pointer, retry count, request fields and failing index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      retry    <= '0;
      req_dev  <= '0;
      req_reg  <= '0;
      req_val  <= '0;
      err_idx  <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN, S_ERR: begin
          if (go) begin
            rom_addr <= '0;
            retry    <= '0;
          end
        end
        S_DECODE: begin
          if (rom_data != END_WORD && rom_data != DELAY_WORD) begin
            req_dev <= DEV_ADDR;
            req_reg <= rom_data[15:8];
            req_val <= rom_data[7:0];
          end
        end
        S_WAITR: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              retry <= '0;
              // The last table slot finishes in place; the pointer never wraps
              if (!at_last) rom_addr <= rom_addr + 1'b1;
            end else if (retry == RETRY_MAX) begin
              err_idx <= rom_addr;
            end else begin
              retry <= retry + 1'b1;
            end
          end
        end
        S_DLY: begin
          if (cnt == DELAY_LAST && !at_last) rom_addr <= rom_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
